// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Walks a small register table and issues one I2C register write per entry
// through I2C_master, with a per-entry watchdog so a stuck bus cannot hang
// the sequence. Runs on the same divided clock as I2C_master.

module i2c_init_sequencer #(
    parameter logic [6:0] DEV_ADDR = 7'b1101000,
    parameter int         NUM_REGS = 4,
    parameter int         IDX_W    = 4,
    parameter int         TMO_CYC  = 4096,
    parameter int         TMO_W    = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_word,
    output logic             i2c_start,
    output logic [6:0]       i2c_addr,
    output logic [7:0]       i2c_sub,
    output logic [7:0]       i2c_data,
    input  logic             i2c_ready,
    input  logic             i2c_done,
    output logic             busy,
    output logic             seq_done,
    output logic             seq_err,
    output logic [IDX_W-1:0] err_idx
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_DONE,
        NEXT,
        FINISH,
        ERROR
    } state_t;

    // An empty table finishes immediately on go without touching the bus.
    localparam bit               EMPTY    = (NUM_REGS == 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             started;
    logic             in_xfer;
    logic             tmo_hit;
    logic             idle_like;

    assign in_xfer   = (state == ISSUE) || (state == WAIT_DONE);
    assign tmo_hit   = in_xfer && (tmo_cnt == TMO_LAST);
    assign idle_like = (state == IDLE) || (state == FINISH) || (state == ERROR);

    // State register plus the table index, latched entry, watchdog and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tbl_idx  <= '0;
            i2c_sub  <= '0;
            i2c_data <= '0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
            err_idx  <= '0;
            tmo_cnt  <= '0;
            started  <= 1'b0;
        end else begin
            state <= next_state;

            if (idle_like && go) begin
                seq_done <= EMPTY;
                seq_err  <= 1'b0;
                busy     <= !EMPTY;
                tbl_idx  <= '0;
            end

            if (state == LATCH) begin
                i2c_sub  <= tbl_word[15:8];
                i2c_data <= tbl_word[7:0];
                tmo_cnt  <= '0;
                started  <= 1'b0;
            end

            if (state == ISSUE && i2c_start) begin
                started <= 1'b1;
            end

            if (in_xfer) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (state == NEXT) begin
                if (tbl_idx == LAST_IDX) begin
                    seq_done <= 1'b1;
                    busy     <= 1'b0;
                end else begin
                    tbl_idx <= tbl_idx + IDX_W'(1);
                end
            end

            if (tmo_hit) begin
                err_idx <= tbl_idx;
                seq_err <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

    // Next-state selection; the watchdog overrides any pending handshake.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, FINISH, ERROR: begin
                if (go) begin
                    next_state = EMPTY ? FINISH : FETCH;
                end
            end
            FETCH:     next_state = LATCH;
            LATCH:     next_state = ISSUE;
            ISSUE: begin
                if (tmo_hit) begin
                    next_state = ERROR;
                end else if (started && !i2c_ready) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tmo_hit) begin
                    next_state = ERROR;
                end else if (i2c_done) begin
                    next_state = NEXT;
                end
            end
            NEXT:      next_state = (tbl_idx == LAST_IDX) ? FINISH : FETCH;
            default:   next_state = IDLE;
        endcase
    end

    // Start is offered only while the master is ready, and never in a watchdog cycle.
    always_comb begin
        i2c_start = 1'b0;
        i2c_addr  = DEV_ADDR;
        if (state == ISSUE && i2c_ready && !tmo_hit) begin
            i2c_start = 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer
// Three sequencers share clock and reset: a normal 3-entry table, a 3-entry
// table with a short watchdog whose master never completes entry 1, and an
// empty table. A behavioural I2C master acknowledges each start after 10 clk.

module tb_i2c_init_sequencer;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] sub;
        logic [7:0] data;
    } txn_t;

    localparam logic [15:0] TABLE [3] = '{16'h200F, 16'h2380, 16'h2400};
    localparam int          ACK_CYC   = 10;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        go        [3];
    logic [3:0]  tbl_idx   [3];
    logic [15:0] tbl_word  [3];
    logic        i2c_start [3];
    logic [6:0]  i2c_addr  [3];
    logic [7:0]  i2c_sub   [3];
    logic [7:0]  i2c_data  [3];
    logic        i2c_ready [3];
    logic        i2c_done  [3];
    logic        busy      [3];
    logic        seq_done  [3];
    logic        seq_err   [3];
    logic [3:0]  err_idx   [3];

    logic        m_ready   [3];
    logic        take      [3];
    int          m_cnt     [3];
    int          acks      [3];
    int          start_cnt [3];

    txn_t        exp_q [$];
    txn_t        obs_q [$];
    int          obs_ptr;
    int          checks;
    int          errors;

    assign i2c_ready[0] = m_ready[0] && !hold;
    assign i2c_ready[1] = m_ready[1];
    assign i2c_ready[2] = m_ready[2];

    i2c_init_sequencer #(.NUM_REGS(3)) dut_main (
        .clk(clk), .reset(reset), .go(go[0]), .tbl_idx(tbl_idx[0]), .tbl_word(tbl_word[0]),
        .i2c_start(i2c_start[0]), .i2c_addr(i2c_addr[0]), .i2c_sub(i2c_sub[0]),
        .i2c_data(i2c_data[0]), .i2c_ready(i2c_ready[0]), .i2c_done(i2c_done[0]),
        .busy(busy[0]), .seq_done(seq_done[0]), .seq_err(seq_err[0]), .err_idx(err_idx[0])
    );

    i2c_init_sequencer #(.NUM_REGS(3), .TMO_CYC(64), .TMO_W(7)) dut_tmo (
        .clk(clk), .reset(reset), .go(go[1]), .tbl_idx(tbl_idx[1]), .tbl_word(tbl_word[1]),
        .i2c_start(i2c_start[1]), .i2c_addr(i2c_addr[1]), .i2c_sub(i2c_sub[1]),
        .i2c_data(i2c_data[1]), .i2c_ready(i2c_ready[1]), .i2c_done(i2c_done[1]),
        .busy(busy[1]), .seq_done(seq_done[1]), .seq_err(seq_err[1]), .err_idx(err_idx[1])
    );

    i2c_init_sequencer #(.NUM_REGS(0)) dut_empty (
        .clk(clk), .reset(reset), .go(go[2]), .tbl_idx(tbl_idx[2]), .tbl_word(tbl_word[2]),
        .i2c_start(i2c_start[2]), .i2c_addr(i2c_addr[2]), .i2c_sub(i2c_sub[2]),
        .i2c_data(i2c_data[2]), .i2c_ready(i2c_ready[2]), .i2c_done(i2c_done[2]),
        .busy(busy[2]), .seq_done(seq_done[2]), .seq_err(seq_err[2]), .err_idx(err_idx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] romLookup(input logic [3:0] idx);
        if (idx < 4'd3) begin
            return TABLE[idx];
        end
        return 16'hDEAD;
    endfunction

    // Registered table ROM per instance: data follows the index by one clock.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            tbl_word[k] <= romLookup(tbl_idx[k]);
        end
    end

    // Mid-cycle monitor: records every start the master is about to accept.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            take[k] = i2c_start[k] && i2c_ready[k];
            if (take[k]) begin
                start_cnt[k] = start_cnt[k] + 1;
                if (k == 0) begin
                    obs_q.push_back({tbl_idx[0], i2c_sub[0], i2c_data[0]});
                end
            end
        end
    end

    // Behavioural master: drop ready on accept, pulse done ACK_CYC clocks later.
    // The watchdog instance never completes its second transaction.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_ready[k]   = 1'b1;
                i2c_done[k]  = 1'b0;
                m_cnt[k]     = 0;
                acks[k]      = 0;
            end else begin
                i2c_done[k] = 1'b0;
                if (m_cnt[k] != 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) begin
                        m_ready[k] = 1'b1;
                        if (!(k == 1 && acks[k] >= 2)) begin
                            i2c_done[k] = 1'b1;
                        end
                    end
                end else if (take[k]) begin
                    m_ready[k] = 1'b0;
                    m_cnt[k]   = ACK_CYC;
                    acks[k]    = acks[k] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse go on one instance and queue the entries it should write (main instance only).
    task automatic applyStimulus(input int k, input int n_entries);
        logic [15:0] e;
        if (k == 0) begin
            for (int i = 0; i < n_entries; i++) begin
                e = TABLE[i];
                exp_q.push_back({4'(i), e[15:8], e[7:0]});
            end
        end
        @(posedge clk); #2;
        go[k] = 1'b1;
        @(posedge clk); #2;
        go[k] = 1'b0;
    endtask

    task automatic drainScoreboard(input string tag);
        txn_t e;
        checkOutput({tag, "_count"}, obs_q.size(), obs_ptr + exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_ptr < obs_q.size()) begin
                checkOutput({tag, "_txn"}, 32'(obs_q[obs_ptr]), 32'(e));
                obs_ptr = obs_ptr + 1;
            end
        end
    endtask

    task automatic waitSeqDone(input int k);
        for (int c = 0; c < 500 && seq_done[k] !== 1'b1; c++) begin
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        checks  = 0;
        errors  = 0;
        obs_ptr = 0;
        hold    = 1'b0;
        reset   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go[k]        = 1'b0;
            start_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_tbl_idx", 32'(tbl_idx[0]), 0);
        checkOutput("rst_start", 32'(i2c_start[0]), 0);
        checkOutput("rst_sub", 32'(i2c_sub[0]), 0);
        checkOutput("rst_data", 32'(i2c_data[0]), 0);
        checkOutput("rst_busy", 32'(busy[0]), 0);
        checkOutput("rst_seq_done", 32'(seq_done[0]), 0);
        checkOutput("rst_seq_err", 32'(seq_err[0]), 0);
        checkOutput("rst_err_idx", 32'(err_idx[0]), 0);
        checkOutput("addr", 32'(i2c_addr[0]), 32'h68);

        $display("[TB] three-entry write and start latency");
        applyStimulus(0, 3);
        @(negedge clk);
        checkOutput("t1_busy", 32'(busy[0]), 1);
        checkOutput("t1_fetch_start", 32'(i2c_start[0]), 0);
        @(negedge clk);
        checkOutput("t1_latch_start", 32'(i2c_start[0]), 0);
        @(negedge clk);
        checkOutput("t1_issue_start", 32'(i2c_start[0]), 1);
        checkOutput("t1_issue_sub", 32'(i2c_sub[0]), 32'h20);
        checkOutput("t1_issue_data", 32'(i2c_data[0]), 32'h0F);

        $display("[TB] go while busy is ignored");
        for (int c = 0; c < 200 && tbl_idx[0] !== 4'd1; c++) begin
            @(negedge clk);
        end
        @(posedge clk); #2;
        go[0] = 1'b1;
        @(posedge clk); #2;
        go[0] = 1'b0;
        waitSeqDone(0);
        checkOutput("t1_seq_done", 32'(seq_done[0]), 1);
        checkOutput("t1_busy_end", 32'(busy[0]), 0);
        checkOutput("t1_starts", 32'(start_cnt[0]), 3);
        drainScoreboard("t1");

        $display("[TB] ready held low at issue");
        hold = 1'b1;
        applyStimulus(0, 3);
        @(negedge clk);
        checkOutput("t3_done_cleared", 32'(seq_done[0]), 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (i2c_start[0] !== 1'b0) bad = bad + 1;
        end
        checkOutput("t3_no_start_held", 32'(bad), 0);
        checkOutput("t3_busy_held", 32'(busy[0]), 1);
        @(posedge clk); #2;
        hold = 1'b0;
        @(negedge clk);
        checkOutput("t3_start_release", 32'(i2c_start[0]), 1);
        waitSeqDone(0);
        checkOutput("t3_seq_done", 32'(seq_done[0]), 1);
        drainScoreboard("t3");

        $display("[TB] watchdog on entry 1");
        applyStimulus(1, 3);
        for (int c = 0; c < 200 && !(i2c_start[1] === 1'b1 && tbl_idx[1] === 4'd1); c++) begin
            @(negedge clk);
        end
        checkOutput("t4_entry1_start", 32'(i2c_start[1]), 1);
        repeat (63) @(negedge clk);
        checkOutput("t4_err_not_yet", 32'(seq_err[1]), 0);
        @(negedge clk);
        checkOutput("t4_seq_err", 32'(seq_err[1]), 1);
        checkOutput("t4_err_idx", 32'(err_idx[1]), 1);
        checkOutput("t4_start_off", 32'(i2c_start[1]), 0);
        checkOutput("t4_seq_done", 32'(seq_done[1]), 0);
        checkOutput("t4_busy", 32'(busy[1]), 0);
        repeat (20) @(negedge clk);
        checkOutput("t4_starts", 32'(start_cnt[1]), 2);

        $display("[TB] empty table");
        applyStimulus(2, 0);
        @(negedge clk);
        checkOutput("t6_seq_done", 32'(seq_done[2]), 1);
        checkOutput("t6_busy", 32'(busy[2]), 0);
        repeat (20) @(negedge clk);
        checkOutput("t6_no_start", 32'(start_cnt[2]), 0);

        $display("[TB] reset during entry 1");
        applyStimulus(0, 2);
        for (int c = 0; c < 200 && obs_q.size() < obs_ptr + 2; c++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_tbl_idx", 32'(tbl_idx[0]), 0);
        checkOutput("t5_start", 32'(i2c_start[0]), 0);
        checkOutput("t5_sub", 32'(i2c_sub[0]), 0);
        checkOutput("t5_data", 32'(i2c_data[0]), 0);
        checkOutput("t5_busy", 32'(busy[0]), 0);
        checkOutput("t5_seq_done", 32'(seq_done[0]), 0);
        checkOutput("t5_err_flags", 32'({seq_err[1], err_idx[1]}), 0);
        applyStimulus(0, 3);
        waitSeqDone(0);
        checkOutput("t5_seq_done_end", 32'(seq_done[0]), 1);
        drainScoreboard("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
